// File: rtl/pc_gen.sv
// pc_gen: program counter owner ahead of ifetch.
// Sequences pc+step, branch/flush redirects, holds a branch resolved under stall.
module pc_gen #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
   parameter logic [31:0] PC_STEP      = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_if,
   input  logic        stall_pipe,
   input  logic        branch_flag,
   input  logic [31:0] branch_target,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic [31:0] pc,
   output logic        en,
   output logic        redirect_pending
);

   logic [31:0] pc_q, pc_d;
   logic        en_q, en_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] pend_target_q, pend_target_d;
   logic        adv;

   assign adv = en_q && !stall_if && !stall_pipe;

   // next-pc selection: flush, then branch/pending on advance, else latch branch
   always_comb begin
      pc_d          = pc_q;
      en_d          = 1'b1;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      if (en_q) begin
         if (flush) begin
            pc_d         = flush_pc;
            pend_valid_d = 1'b0;
         end else if (adv && branch_flag) begin
            pc_d         = branch_target;
            pend_valid_d = 1'b0;
         end else if (adv && pend_valid_q) begin
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
         end else if (adv) begin
            pc_d = pc_q + PC_STEP;
         end else if (branch_flag) begin
            pend_valid_d  = 1'b1;
            pend_target_d = branch_target;
         end
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_VECTOR;
         en_q          <= 1'b0;
         pend_valid_q  <= 1'b0;
         pend_target_q <= 32'd0;
      end else begin
         pc_q          <= pc_d;
         en_q          <= en_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
      end
   end

   assign pc               = pc_q;
   assign en               = en_q;
   assign redirect_pending = pend_valid_q;

endmodule
